// File: rtl/hit_count_display_if.sv
// Bus bundle between the hit-count source and the BCD/7-segment display block.
// It carries the capture strobe, the converted result and the display drive.
interface hit_count_display_if #(
  parameter int unsigned NumDig = 4,
  parameter int unsigned DataW  = 14
);
  logic [DataW-1:0]    i_data;
  logic                i_valid;
  logic [NumDig*4-1:0] o_bcd;
  logic                o_bcd_valid;
  logic                o_ovf;
  logic                o_busy;
  logic [6:0]          o_seg;
  logic [NumDig-1:0]   o_an;

  modport master (
    output i_data, i_valid,
    input  o_bcd, o_bcd_valid, o_ovf, o_busy, o_seg, o_an
  );

  modport slave (
    input  i_data, i_valid,
    output o_bcd, o_bcd_valid, o_ovf, o_busy, o_seg, o_an
  );
endinterface

// File: rtl/hit_count_display.sv
// Captures binary hit counts, converts them to saturated packed BCD with a
// sequential double-dabble engine and scans them onto a multiplexed 7-seg display.
module hit_count_display #(
  parameter int unsigned NumDig  = 4,
  parameter int unsigned DataW   = 14,
  parameter int unsigned ScanDiv = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  hit_count_display_if.slave bus
);

  localparam int unsigned BcdW   = NumDig * 4;
  localparam int unsigned MaxVal = (10 ** NumDig) - 1;
  localparam int unsigned MaxW   = $clog2(MaxVal + 1);
  localparam int unsigned CmpW   = (DataW > MaxW) ? DataW : MaxW;
  localparam int unsigned CntW   = (DataW > 1) ? $clog2(DataW) : 1;
  localparam int unsigned ScanW  = $clog2(ScanDiv);
  localparam int unsigned IdxW   = (NumDig > 1) ? $clog2(NumDig) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DataW-1:0]  work_q, work_d;
  logic [BcdW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_nxt_q, ovf_nxt_d;
  logic [DataW-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              bcd_vld_q, bcd_vld_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [ScanW-1:0]  scan_q, scan_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [BcdW-1:0]   adj_c;
  logic [NumDig-1:0] lit_c;
  logic              nz_above_c;
  logic [3:0]        digit_c;
  logic [6:0]        seg_c;
  logic [NumDig-1:0] an_c;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    adj_c = acc_q;
    for (int i = 0; i < int'(NumDig); i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj_c[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM, capture and pending-buffer control.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_nxt_d  = ovf_nxt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    bcd_vld_d  = 1'b0;

    if (bus.i_valid && (state_q != S_IDLE)) begin
      pend_d     = bus.i_data;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          work_d  = bus.i_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (CmpW'(work_q) > CmpW'(MaxVal)) begin
          work_d    = DataW'(MaxVal);
          ovf_nxt_d = 1'b1;
        end else begin
          ovf_nxt_d = 1'b0;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {acc_d, work_d} = {adj_c[BcdW-2:0], work_q, 1'b0};
        cnt_d           = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DataW - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d     = acc_q;
        ovf_d     = ovf_nxt_q;
        bcd_vld_d = 1'b1;
        // A strobe landing in this cycle counts as pending and wins over an older one.
        if (pend_vld_q || bus.i_valid) begin
          work_d     = bus.i_valid ? bus.i_data : pend_q;
          pend_vld_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Free-running digit scan.
  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanW'(ScanDiv - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IdxW'(NumDig - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Leading-zero blanking mask; digit 0 always lit.
  always_comb begin
    nz_above_c = 1'b0;
    lit_c      = '0;
    for (int i = int'(NumDig) - 1; i >= 0; i--) begin
      nz_above_c = nz_above_c | (bcd_q[i*4 +: 4] != 4'd0);
      lit_c[i]   = nz_above_c;
    end
    lit_c[0] = 1'b1;
  end

  always_comb begin
    digit_c = bcd_q[4*int'(idx_q) +: 4];
    case (digit_c)
      4'd0:    seg_c = 7'h40;
      4'd1:    seg_c = 7'h79;
      4'd2:    seg_c = 7'h24;
      4'd3:    seg_c = 7'h30;
      4'd4:    seg_c = 7'h19;
      4'd5:    seg_c = 7'h12;
      4'd6:    seg_c = 7'h02;
      4'd7:    seg_c = 7'h78;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h10;
      default: seg_c = 7'h7F;
    endcase
    if (!lit_c[idx_q]) seg_c = 7'h7F;
    an_c = ~(NumDig'(1) << idx_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_nxt_q  <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
      bcd_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_nxt_q  <= ovf_nxt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bcd_q      <= bcd_d;
      bcd_vld_q  <= bcd_vld_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.o_bcd       = bcd_q;
  assign bus.o_bcd_valid = bcd_vld_q;
  assign bus.o_ovf       = ovf_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_seg       = seg_c;
  assign bus.o_an        = an_c;

endmodule

// File: tb/tb_hit_count_display.sv
// Scoreboard bench for hit_count_display: expected conversions are queued at
// stimulus time and popped on each o_bcd_valid; the scan is checked against a reference model.
module tb_hit_count_display;

  localparam int unsigned NumDig  = 4;
  localparam int unsigned DataW   = 14;
  localparam int unsigned ScanDiv = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hit_count_display_if #(.NumDig(NumDig), .DataW(DataW)) bus ();

  hit_count_display #(.NumDig(NumDig), .DataW(DataW), .ScanDiv(ScanDiv)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   m_cnt    = 0;
  int   m_idx    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int v);
    int p;
    int d;
    p = 10 ** idx;
    if (idx > 0 && (v / p) == 0) return 7'h7F;
    d = (v / p) % 10;
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == int'(ScanDiv) - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx == int'(NumDig) - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) if (bus.o_busy) busy_cnt <= busy_cnt + 1;

  // Output side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.o_bcd_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.o_bcd), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("bcd", 32'(bus.o_bcd), 32'(e.bcd));
        check("ovf", 32'(bus.o_ovf), 32'(e.ovf));
        if (e.start >= 0) check("latency", 32'(cyc - e.start), 32'd16);
      end
    end
  end

  task automatic send(input int v, input bit push, input bit timed);
    exp_t e;
    @(negedge clk);
    bus.i_data  = DataW'(v);
    bus.i_valid = 1'b1;
    if (push) begin
      e.bcd   = to_bcd(v);
      e.ovf   = (v > 9999);
      e.start = timed ? cyc + 1 : -1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_scan(input int v);
    for (int i = 0; i < 2 * int'(NumDig * ScanDiv); i++) begin
      @(negedge clk);
      check("an", 32'(bus.o_an), 32'(4'(~(4'b0001 << m_idx))));
      check("seg", 32'(bus.o_seg), 32'(exp_seg(m_idx, v)));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bcd"}, 32'(bus.o_bcd), 32'd0);
    check({tag, "_bcd_valid"}, 32'(bus.o_bcd_valid), 32'd0);
    check({tag, "_ovf"}, 32'(bus.o_ovf), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_an"}, 32'(bus.o_an), 32'(4'b1110));
    check({tag, "_seg"}, 32'(bus.o_seg), 32'h40);
  endtask

  initial begin
    int b0;
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
    #12;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversion, latency and busy width
    b0 = busy_cnt;
    send(1234, 1, 1);
    drain();
    check("busy_len_1234", 32'(busy_cnt - b0), 32'd16);
    check("hold_bcd", 32'(bus.o_bcd), 32'h1234);

    // Saturation then return to zero
    send(12000, 1, 1);
    drain();
    send(0, 1, 1);
    drain();
    send(9999, 1, 1);
    drain();
    send(10000, 1, 1);
    drain();

    // Pending buffer overwrite: 42 is dropped
    b0 = busy_cnt;
    send(5, 1, 1);
    send(42, 0, 0);
    send(77, 1, 0);
    drain();
    check("busy_len_pending", 32'(busy_cnt - b0), 32'd32);

    // Display scan with blanking
    send(7, 1, 1);
    drain();
    check_scan(7);
    send(1005, 1, 1);
    drain();
    check_scan(1005);
    send(40, 1, 1);
    drain();
    check_scan(40);

    // Reset during SHIFT cycle 7 aborts the conversion
    send(12000, 1, 1);
    drain();
    check("ovf_before_rst", 32'(bus.o_ovf), 32'd1);
    send(1234, 0, 0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_valid_after_abort", 32'(bus.o_bcd), 32'd0);
    send(9999, 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", sb_q.size(), 0);
    $fatal(1, "timeout");
  end

endmodule
